// File: rtl/red_pitaya_dsp_router.sv
// red_pitaya_dsp_router
//   Routes N_SRC signed sources onto N_SINK sinks, and sums masked direct
//   outputs onto N_DAC saturated DAC channels through a pipelined adder tree.
//   Routing selects and DAC masks are held in shadow registers. They are
//   copied to the active registers in one step (COMMIT), or on every shadow
//   write when AUTO is set.
// Ports:
//   clk_i, rst_i      processing clock, synchronous active-high reset
//   src_i / dir_i     packed routable sources / direct outputs, DW bits each
//   sink_o            registered selected source per sink
//   dac_o, sat_o      saturated channel sums and live clamp flags
//   sys_*             register bus; ack/rdata/err one cycle after a strobe
module red_pitaya_dsp_router #(
  parameter int DW     = 14,
  parameter int N_SRC  = 16,
  parameter int N_SINK = 10,
  parameter int N_DAC  = 2,
  parameter int SEL_W  = 4,
  parameter int SUM_W  = DW + SEL_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_SRC*DW-1:0]    src_i,
  input  logic [N_SRC*DW-1:0]    dir_i,
  output logic [N_SINK*DW-1:0]   sink_o,
  output logic [N_DAC*DW-1:0]    dac_o,
  output logic [N_DAC-1:0]       sat_o,
  input  logic [15:0]            sys_addr,
  input  logic [31:0]            sys_wdata,
  input  logic                   sys_wen,
  input  logic                   sys_ren,
  output logic [31:0]            sys_rdata,
  output logic                   sys_ack,
  output logic                   sys_err
);

  // Tree depth and leaf count padded to a power of two (heap layout: node 1
  // is the root, node n has children 2n and 2n+1, leaves are NP..2NP-1).
  localparam int LVL = (N_SRC > 1) ? $clog2(N_SRC) : 0;
  localparam int NP  = 1 << LVL;

  localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DW-1:0] v);
    return {{(SUM_W-DW){v[DW-1]}}, v};
  endfunction

  logic signed [DW-1:0]    src_a_s [N_SRC];
  logic signed [DW-1:0]    dir_a_s [N_SRC];
  logic [SEL_W-1:0]        shadow_sel_r [N_SINK];
  logic [SEL_W-1:0]        active_sel_r [N_SINK];
  logic [N_DAC-1:0]        shadow_mask_r [N_SRC];
  logic [N_DAC-1:0]        active_mask_r [N_SRC];
  logic                    auto_r;
  logic [DW-1:0]           sink_r [N_SINK];
  logic [DW-1:0]           sink_next_s [N_SINK];
  logic signed [SUM_W-1:0] leaf_s [N_DAC][NP];
  logic signed [SUM_W-1:0] node_r [N_DAC][1:2*NP-1];
  logic [DW-1:0]           dac_r [N_DAC];
  logic [DW-1:0]           dac_next_s [N_DAC];
  logic [N_DAC-1:0]        sat_r;
  logic [N_DAC-1:0]        sat_next_s;
  logic [N_DAC-1:0]        sticky_r;
  logic [31:0]             cnt_r [N_DAC];
  logic [N_SINK-1:0]       sel_wr_s;
  logic [N_SRC-1:0]        mask_wr_s;
  logic [N_DAC-1:0]        cnt_wr_s;
  logic                    ctrl_wr_s;
  logic                    stat_wr_s;
  logic                    commit_s;
  logic                    hit_s;
  logic [31:0]             rd_data_s;
  logic [31:0]             status_s;
  logic [31:0]             rdata_r;
  logic                    ack_r;
  logic                    err_r;
  logic                    unused_s;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_unpack
      assign src_a_s[gi] = src_i[gi*DW +: DW];
      assign dir_a_s[gi] = dir_i[gi*DW +: DW];
    end
    for (gi = 0; gi < N_SINK; gi++) begin : g_sink_out
      assign sink_o[gi*DW +: DW] = sink_r[gi];
    end
    for (gi = 0; gi < N_DAC; gi++) begin : g_dac_out
      assign dac_o[gi*DW +: DW] = dac_r[gi];
    end
  endgenerate

  assign sat_o     = sat_r;
  assign sys_rdata = rdata_r;
  assign sys_ack   = ack_r;
  assign sys_err   = err_r;
  assign unused_s  = ^sys_wdata;

  // Address decode: one-hot write enables and OR-combined read mux.
  always_comb begin
    rd_data_s = 32'h0;
    hit_s     = 1'b0;
    sel_wr_s  = '0;
    mask_wr_s = '0;
    cnt_wr_s  = '0;
    status_s  = 32'h0;
    for (int c = 0; c < N_DAC; c++) begin
      status_s[c]     = sat_r[c];
      status_s[8 + c] = sticky_r[c];
    end
    for (int k = 0; k < N_SINK; k++) begin
      sel_wr_s[k] = sys_wen && (sys_addr == 16'(4*k));
      hit_s       = hit_s | (sys_addr == 16'(4*k));
      rd_data_s   = rd_data_s | ((sys_addr == 16'(4*k)) ? 32'(shadow_sel_r[k]) : 32'h0);
    end
    for (int j = 0; j < N_SRC; j++) begin
      mask_wr_s[j] = sys_wen && (sys_addr == 16'(256 + 4*j));
      hit_s        = hit_s | (sys_addr == 16'(256 + 4*j));
      rd_data_s    = rd_data_s | ((sys_addr == 16'(256 + 4*j)) ? 32'(shadow_mask_r[j]) : 32'h0);
    end
    for (int c = 0; c < N_DAC; c++) begin
      cnt_wr_s[c] = sys_wen && (sys_addr == 16'(520 + 4*c));
      hit_s       = hit_s | (sys_addr == 16'(520 + 4*c));
      rd_data_s   = rd_data_s | ((sys_addr == 16'(520 + 4*c)) ? cnt_r[c] : 32'h0);
    end
    hit_s     = hit_s | (sys_addr == 16'h0200) | (sys_addr == 16'h0204);
    rd_data_s = rd_data_s | ((sys_addr == 16'h0200) ? {30'h0, auto_r, 1'b0} : 32'h0);
    rd_data_s = rd_data_s | ((sys_addr == 16'h0204) ? status_s : 32'h0);
  end

  assign ctrl_wr_s = sys_wen && (sys_addr == 16'h0200);
  assign stat_wr_s = sys_wen && (sys_addr == 16'h0204);
  assign commit_s  = ctrl_wr_s && sys_wdata[0];

  // Shadow/active routing registers and the AUTO flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_SINK; k++) begin
        shadow_sel_r[k] <= SEL_W'(k % N_SRC);
        active_sel_r[k] <= SEL_W'(k % N_SRC);
      end
      for (int j = 0; j < N_SRC; j++) begin
        shadow_mask_r[j] <= '0;
        active_mask_r[j] <= '0;
      end
      auto_r <= 1'b1;
    end else begin
      for (int k = 0; k < N_SINK; k++) begin
        if (sel_wr_s[k]) shadow_sel_r[k] <= sys_wdata[SEL_W-1:0];
      end
      for (int j = 0; j < N_SRC; j++) begin
        if (mask_wr_s[j]) shadow_mask_r[j] <= sys_wdata[N_DAC-1:0];
      end
      if (ctrl_wr_s) auto_r <= sys_wdata[1];
      // Commit copies the pre-write shadows so every sink and mask moves together.
      if (commit_s) begin
        active_sel_r  <= shadow_sel_r;
        active_mask_r <= shadow_mask_r;
      end else if (auto_r) begin
        for (int k = 0; k < N_SINK; k++) begin
          if (sel_wr_s[k]) active_sel_r[k] <= sys_wdata[SEL_W-1:0];
        end
        for (int j = 0; j < N_SRC; j++) begin
          if (mask_wr_s[j]) active_mask_r[j] <= sys_wdata[N_DAC-1:0];
        end
      end
    end
  end

  // Sink mux: out-of-range selects produce zero.
  always_comb begin
    for (int k = 0; k < N_SINK; k++) begin
      sink_next_s[k] = '0;
      for (int j = 0; j < N_SRC; j++) begin
        sink_next_s[k] = (active_sel_r[k] == SEL_W'(j)) ? src_a_s[j] : sink_next_s[k];
      end
    end
  end

  // Sink output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_SINK; k++) sink_r[k] <= '0;
    end else begin
      sink_r <= sink_next_s;
    end
  end

  // Masked, sign-extended tree leaves; padding leaves stay zero.
  always_comb begin
    for (int c = 0; c < N_DAC; c++) begin
      for (int j = 0; j < NP; j++) leaf_s[c][j] = '0;
      for (int j = 0; j < N_SRC; j++) begin
        leaf_s[c][j] = active_mask_r[j][c] ? sext(dir_a_s[j]) : '0;
      end
    end
  end

  // Adder tree: leaves plus one register per level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < N_DAC; c++) begin
        for (int n = 1; n < 2*NP; n++) node_r[c][n] <= '0;
      end
    end else begin
      for (int c = 0; c < N_DAC; c++) begin
        for (int n = 1; n < NP; n++) node_r[c][n] <= node_r[c][2*n] + node_r[c][2*n+1];
        for (int j = 0; j < NP; j++) node_r[c][NP+j] <= leaf_s[c][j];
      end
    end
  end

  // Clamp of the tree root to the DW-bit signed range.
  always_comb begin
    for (int c = 0; c < N_DAC; c++) begin
      sat_next_s[c] = (node_r[c][1] > MAX_V) || (node_r[c][1] < MIN_V);
      dac_next_s[c] = (node_r[c][1] > MAX_V) ? MAX_V[DW-1:0] :
                      (node_r[c][1] < MIN_V) ? MIN_V[DW-1:0] : node_r[c][1][DW-1:0];
    end
  end

  // DAC output registers and live saturation flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < N_DAC; c++) dac_r[c] <= '0;
      sat_r <= '0;
    end else begin
      dac_r <= dac_next_s;
      sat_r <= sat_next_s;
    end
  end

  // Sticky flags (set beats clear) and saturating per-channel counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_r <= '0;
      for (int c = 0; c < N_DAC; c++) cnt_r[c] <= 32'h0;
    end else begin
      for (int c = 0; c < N_DAC; c++) begin
        sticky_r[c] <= (sticky_r[c] & ~(stat_wr_s & sys_wdata[8 + c])) | sat_r[c];
        if (cnt_wr_s[c]) begin
          cnt_r[c] <= sat_r[c] ? 32'd1 : 32'd0;
        end else if (sat_r[c] && (cnt_r[c] != 32'hFFFF_FFFF)) begin
          cnt_r[c] <= cnt_r[c] + 32'd1;
        end
      end
    end
  end

  // Bus response; read data reflects the state before any same-cycle write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0;
    end else begin
      ack_r   <= sys_wen | sys_ren;
      err_r   <= (sys_wen | sys_ren) & ~hit_s;
      rdata_r <= sys_ren ? rd_data_s : 32'h0;
    end
  end

endmodule

// File: tb/tb_red_pitaya_dsp_router.sv
module tb_red_pitaya_dsp_router;
  localparam int DW = 14, N_SRC = 16, N_SINK = 10, N_DAC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_i;
  logic [N_SRC*DW-1:0]  src_i, dir_i;
  logic [N_SINK*DW-1:0] sink_o, sink12;
  logic [N_DAC*DW-1:0]  dac_o, dac12;
  logic [N_DAC-1:0]     sat_o, sat12;
  logic [15:0]          sys_addr;
  logic [31:0]          sys_wdata, sys_rdata, rdata12;
  logic                 sys_wen, sys_ren, sys_ack, sys_err, ack12, err12;

  red_pitaya_dsp_router u_dut (
    .clk_i(clk), .rst_i(rst_i), .src_i(src_i), .dir_i(dir_i),
    .sink_o(sink_o), .dac_o(dac_o), .sat_o(sat_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err));

  red_pitaya_dsp_router #(.N_SRC(12)) u_dut12 (
    .clk_i(clk), .rst_i(rst_i), .src_i(src_i[12*DW-1:0]), .dir_i(dir_i[12*DW-1:0]),
    .sink_o(sink12), .dac_o(dac12), .sat_o(sat12),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(rdata12), .sys_ack(ack12), .sys_err(err12));

  typedef struct {int due; longint d0; longint d1; logic [1:0] sat;} sb_t;
  typedef struct {int d2; int d3; int e0; int e1; logic [1:0] s;} vec_t;
  sb_t  sbq[$];
  vec_t vt[7];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] rd_d, cnt_a, cnt_b;
  logic        rd_e;

  function automatic longint sink_v(int k);
    return longint'($signed(sink_o[k*DW +: DW]));
  endfunction
  function automatic longint sink12_v(int k);
    return longint'($signed(sink12[k*DW +: DW]));
  endfunction
  function automatic longint dac_v(int c);
    return longint'($signed(dac_o[c*DW +: DW]));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check("sb_due", cyc, e.due);
      check("sb_dac0", dac_v(0), e.d0);
      check("sb_dac1", dac_v(1), e.d1);
      check("sb_sat", longint'(sat_o), longint'(e.sat));
    end
  endtask

  task automatic set_dir(input int j, input int v);
    dir_i[j*DW +: DW] = DW'(v);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    step();
    sys_wen = 1'b0;
    check("wr_ack", longint'(sys_ack), 1);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic e);
    sys_addr = a; sys_ren = 1'b1;
    step();
    sys_ren = 1'b0;
    check("rd_ack", longint'(sys_ack), 1);
    d = sys_rdata;
    e = sys_err;
  endtask

  initial begin
    vt[0] = '{1000, -300, 700, -300, 2'b00};
    vt[1] = '{0, 0, 0, 0, 2'b00};
    vt[2] = '{-5000, 2000, -3000, 2000, 2'b00};
    vt[3] = '{8191, 8191, 8191, 8191, 2'b01};
    vt[4] = '{-8192, -8192, -8192, -8192, 2'b01};
    vt[5] = '{4000, 4191, 8191, 4191, 2'b00};
    vt[6] = '{-4096, -4096, -8192, -4096, 2'b00};

    rst_i = 1'b1; dir_i = '0; sys_addr = 16'h0; sys_wdata = 32'h0;
    sys_wen = 1'b0; sys_ren = 1'b0;
    for (int j = 0; j < N_SRC; j++) src_i[j*DW +: DW] = DW'(100*j);

    // Reset state
    repeat (3) step();
    check("rst_dac0", dac_v(0), 0);
    check("rst_sink0", sink_v(0), 0);
    check("rst_ack", longint'(sys_ack), 0);
    rst_i = 1'b0;
    step();
    for (int k = 0; k < N_SINK; k++) check("init_sink", sink_v(k), 100*(k % 16));
    check("init_dac0", dac_v(0), 0);
    check("init_dac1", dac_v(1), 0);

    // Shadow routing with AUTO off, then atomic commit
    wr(16'h0200, 32'h0);
    wr(16'h0000, 32'd5);
    wr(16'h0004, 32'd6);
    check("pre_sink0", sink_v(0), 0);
    check("pre_sink1", sink_v(1), 100);
    rd(16'h0000, rd_d, rd_e);
    check("shadow_rd", longint'(rd_d), 5);
    wr(16'h0200, 32'h1);
    check("commit_edge_sink0", sink_v(0), 0);
    check("commit_edge_sink1", sink_v(1), 100);
    step();
    check("post_sink0", sink_v(0), 500);
    check("post_sink1", sink_v(1), 600);
    rd(16'h0200, rd_d, rd_e);
    check("ctrl_rd", longint'(rd_d), 0);
    wr(16'h0008, 32'd15);
    wr(16'h000C, 32'd13);
    wr(16'h0200, 32'h1);
    step();
    check("sel15", sink_v(2), 1500);
    check("sel13", sink_v(3), 1300);
    check("n12_sel15", sink12_v(2), 0);
    check("n12_sel13", sink12_v(3), 0);
    check("n12_sink0", sink12_v(0), 500);
    wr(16'h0200, 32'h2);
    rd(16'h0200, rd_d, rd_e);
    check("ctrl_auto", longint'(rd_d), 2);
    wr(16'h0010, 32'd7);
    step();
    check("auto_sink4", sink_v(4), 700);

    // Masks and table-driven DAC sums through the scoreboard
    wr(16'h0108, 32'd1);
    wr(16'h010C, 32'd3);
    for (int i = 0; i < 7; i++) begin
      set_dir(2, vt[i].d2);
      set_dir(3, vt[i].d3);
      sbq.push_back('{cyc + 6, longint'(vt[i].e0), longint'(vt[i].e1), vt[i].s});
      step();
    end
    set_dir(2, 0); set_dir(3, 0);
    repeat (8) step();
    check("sb_empty", sbq.size(), 0);

    // Positive saturation, sticky and counter
    for (int j = 4; j < 8; j++) wr(16'(256 + 4*j), 32'd1);
    for (int j = 4; j < 8; j++) set_dir(j, 8191);
    repeat (7) step();
    check("satp_dac0", dac_v(0), 8191);
    check("satp_sat", longint'(sat_o), 1);
    rd(16'h0204, rd_d, rd_e);
    check("satp_status", longint'(rd_d), 32'h101);
    rd(16'h0208, cnt_a, rd_e);
    step();
    rd(16'h0208, cnt_b, rd_e);
    check("cnt_incr", longint'(cnt_b - cnt_a), 2);
    for (int j = 4; j < 8; j++) set_dir(j, 0);
    repeat (8) step();
    check("unsat_live", longint'(sat_o), 0);
    check("unsat_dac0", dac_v(0), 0);
    rd(16'h0204, rd_d, rd_e);
    check("sticky_hold", longint'(rd_d), 32'h100);
    wr(16'h0204, 32'h100);
    rd(16'h0204, rd_d, rd_e);
    check("sticky_clr", longint'(rd_d), 0);
    wr(16'h0208, 32'h0);
    rd(16'h0208, rd_d, rd_e);
    check("cnt_clr", longint'(rd_d), 0);
    rd(16'h020C, rd_d, rd_e);
    check("cnt1_zero", longint'(rd_d), 0);

    // Negative saturation, same-cycle set/clear conflicts
    for (int j = 4; j < 8; j++) set_dir(j, -8192);
    repeat (7) step();
    check("satn_dac0", dac_v(0), -8192);
    check("satn_sat", longint'(sat_o), 1);
    wr(16'h0204, 32'h100);
    rd(16'h0204, rd_d, rd_e);
    check("sticky_setwins", longint'(rd_d), 32'h101);
    wr(16'h0208, 32'h5);
    rd(16'h0208, rd_d, rd_e);
    check("cnt_clr_sat", longint'(rd_d), 1);
    for (int j = 4; j < 8; j++) set_dir(j, 0);
    repeat (8) step();

    // Bus corner cases
    rd(16'h03F0, rd_d, rd_e);
    check("unmap_err", longint'(rd_e), 1);
    check("unmap_data", longint'(rd_d), 0);
    wr(16'h03F0, 32'hFFFF_FFFF);
    check("unmap_wr_err", longint'(sys_err), 1);
    rd(16'h0000, rd_d, rd_e);
    check("mapped_err", longint'(rd_e), 0);
    check("sel0_intact", longint'(rd_d), 5);
    sys_addr = 16'h0008; sys_wdata = 32'd9; sys_wen = 1'b1; sys_ren = 1'b1;
    step();
    sys_wen = 1'b0; sys_ren = 1'b0;
    check("wr_rd_ack", longint'(sys_ack), 1);
    check("wr_rd_old", longint'(sys_rdata), 15);
    step();
    check("ack_pulse", longint'(sys_ack), 0);
    rd(16'h0008, rd_d, rd_e);
    check("wr_rd_new", longint'(rd_d), 9);

    // Reset with a full tree
    set_dir(2, 1000);
    repeat (7) step();
    check("full_dac0", dac_v(0), 1000);
    rst_i = 1'b1;
    step();
    check("midrst_dac0", dac_v(0), 0);
    check("midrst_sat", longint'(sat_o), 0);
    check("midrst_sink1", sink_v(1), 0);
    rst_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("flush_dac0", dac_v(0), 0);
    end
    check("rst_sink1", sink_v(1), 100);
    rd(16'h0000, rd_d, rd_e);
    check("rst_sel0", longint'(rd_d), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
